scard_tx_sequencer: RTL and testbench
=====================================

// Module: scard_tx_sequencer
// PURPOSE
//  Byte-level ISO 7816 T=0 transmit sequencer for the smartcard async transmitter.
//  - Accepts bytes over a valid/ready handshake and starts the transmitter.
//  - Samples the card I/O line for the T=0 error signal (NACK) and retransmits on NACK, up to MAX_RETRY times.
//  - Enforces character guard time, plus a programmable extra guard, between bytes.
// PARAMETERS
//  ETU_CLKS    372   clk cycles per elementary time unit (ETU); must match transmitter baud
//  ERR_SAMPLE  4278  clk cycles from tx_start pulse to io_in NACK sample point (11.5 ETU)
//  GUARD_ETU   2     guard ETUs after tx_busy falls, before next start
//  MAX_RETRY   4     retransmissions allowed per byte after NACK
//  RETRY_W     3     width of retry counter; must satisfy 2**RETRY_W > MAX_RETRY
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous reset, active-high
//  in_valid     in   1        upstream byte valid
//  in_data      in   8        upstream byte
//  in_ready     out  1        byte accepted when in_valid & in_ready
//  extra_guard  in   8        additional guard ETUs (N from ATR); sampled at accept
//  abort        in   1        cancel current byte, return to idle
//  tx_start     out  1        one-cycle start pulse to transmitter
//  tx_data      out  8        byte to transmitter; stable from LOAD until back to IDLE
//  tx_busy      in   1        transmitter busy
//  io_in        in   1        raw card I/O line (asynchronous; synchronised internally)
//  byte_done    out  1        one-cycle pulse: byte sent without NACK
//  byte_fail    out  1        one-cycle pulse: byte NACKed after MAX_RETRY retries
//  retry_cnt    out  RETRY_W  retries used on current/last byte
//  nack_total   out  16       saturating count of all NACKs seen since reset
//  active       out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except in_ready=1; counters and tx_data cleared.
//  io_in: 2-flop synchroniser; ERR_SAMPLE already includes its 2-cycle latency.
//  States:
//   IDLE: in_ready = ~abort. On handshake: latch in_data -> tx_data, extra_guard,
//     clear retry_cnt -> LOAD.
//   LOAD: tx_start=1 for exactly this cycle; clear cyc counter and nack flag -> WAIT_BUSY.
//   WAIT_BUSY: wait until tx_busy=1 -> SEND.
//   SEND: at cyc==ERR_SAMPLE, sample synced io_in; 0 sets nack flag.
//     Go to GUARD when tx_busy=0 AND cyc>ERR_SAMPLE.
//   GUARD: wait (GUARD_ETU + extra_guard) * ETU_CLKS cycles, using ETU sub-counter
//     and ETU counter (no multiplier). Then:
//     - no nack: pulse byte_done -> IDLE.
//     - nack and retry_cnt<MAX_RETRY: retry_cnt++ -> LOAD.
//     - nack and retry_cnt==MAX_RETRY: pulse byte_fail -> IDLE.
//   DRAIN: entered on abort from any non-IDLE state. Stays until tx_busy=0 -> IDLE.
//     No done/fail pulse; tx_start never asserted.
//  nack_total increments once per sampled NACK; saturates at 16'hFFFF.
//  cyc is 16-bit; it saturates (no wrap), so a late sample can never false-trigger.
//  abort has priority over every other transition, including a same-cycle handshake.
//  Handshake latency: accept -> tx_start asserted the next cycle.
//  Back-to-back bytes: in_ready re-asserts the cycle after byte_done or byte_fail.
//  Async rst mid-byte: FSM returns to IDLE immediately; the transmitter is reset
//   by the same rst.
// TESTING (bench: ETU_CLKS=8, ERR_SAMPLE=92, GUARD_ETU=2, MAX_RETRY=2)
//  1. Send 8'hA5, io_in=1, extra_guard=0 -> one tx_start; byte_done 16 cycles after
//     tx_busy falls; retry_cnt=0.
//  2. Send 8'h3C; card drives io_in=0 on first attempt only -> two tx_start pulses;
//     then byte_done; retry_cnt=1; nack_total=1.
//  3. Send 8'hFF; NACK every attempt -> 3 tx_start pulses; then byte_fail;
//     retry_cnt=2; nack_total=3.
//  4. extra_guard=3 -> GUARD lasts 40 cycles; a new in_valid is not accepted
//     before byte_done.
//  5. abort in SEND -> DRAIN until tx_busy=0, then IDLE; no byte_done/byte_fail;
//     in_ready=1 after.
//  6. Assert rst mid-GUARD -> all outputs at reset values on the same edge;
//     no pulse after release.

Source files
------------

// File: rtl/scard_tx_sequencer.sv
// ISO 7816 T=0 byte transmit sequencer: hands bytes to the async transmitter,
// watches the card I/O line for the error signal, retransmits on NACK and enforces guard time.
module scard_tx_sequencer #(
    parameter int ETU_CLKS   = 372,
    parameter int ERR_SAMPLE = 4278,
    parameter int GUARD_ETU  = 2,
    parameter int MAX_RETRY  = 4,
    parameter int RETRY_W    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    input  logic [7:0]         in_data_i,
    output logic               in_ready_o,
    input  logic [7:0]         extra_guard_i,
    input  logic               abort_i,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    input  logic               io_in_i,
    output logic               byte_done_o,
    output logic               byte_fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [15:0]        nack_total_o,
    output logic               active_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_SEND,
        S_GUARD,
        S_DRAIN
    } state_e;

    localparam logic [15:0]        ERR_S      = 16'(ERR_SAMPLE);
    localparam logic [15:0]        ETU_LAST   = 16'(ETU_CLKS - 1);
    localparam logic [RETRY_W-1:0] MAX_R      = RETRY_W'(MAX_RETRY);
    localparam logic [9:0]         GUARD_BASE = 10'(GUARD_ETU);

    state_e             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [7:0]         eguard_q, eguard_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [15:0]        cyc_q, cyc_d;
    logic               nack_q, nack_d;
    logic [15:0]        etu_sub_q, etu_sub_d;
    logic [9:0]         etu_cnt_q, etu_cnt_d;
    logic [15:0]        nack_total_q, nack_total_d;
    logic               io_meta_q, io_sync_q;

    logic [15:0] cyc_inc;
    logic [9:0]  guard_total;
    logic        guard_done;

    // Saturating cycle counter so a stalled transmitter cannot wrap back onto the sample point.
    assign cyc_inc     = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    assign guard_total = GUARD_BASE + {2'b00, eguard_q};
    assign guard_done  = (guard_total == 10'd0) ||
                         ((etu_sub_q == ETU_LAST) && (etu_cnt_q == guard_total - 10'd1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            tx_data_q    <= 8'h00;
            eguard_q     <= 8'h00;
            retry_q      <= '0;
            cyc_q        <= 16'h0000;
            nack_q       <= 1'b0;
            etu_sub_q    <= 16'h0000;
            etu_cnt_q    <= 10'h000;
            nack_total_q <= 16'h0000;
            io_meta_q    <= 1'b1;
            io_sync_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            eguard_q     <= eguard_d;
            retry_q      <= retry_d;
            cyc_q        <= cyc_d;
            nack_q       <= nack_d;
            etu_sub_q    <= etu_sub_d;
            etu_cnt_q    <= etu_cnt_d;
            nack_total_q <= nack_total_d;
            io_meta_q    <= io_in_i;
            io_sync_q    <= io_meta_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        eguard_d     = eguard_q;
        retry_d      = retry_q;
        cyc_d        = cyc_q;
        nack_d       = nack_q;
        etu_sub_d    = etu_sub_q;
        etu_cnt_d    = etu_cnt_q;
        nack_total_d = nack_total_q;
        in_ready_o   = 1'b0;
        tx_start_o   = 1'b0;
        byte_done_o  = 1'b0;
        byte_fail_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_o = ~abort_i;
                if (in_valid_i && !abort_i) begin
                    tx_data_d = in_data_i;
                    eguard_d  = extra_guard_i;
                    retry_d   = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_start_o = 1'b1;
                cyc_d      = 16'h0000;
                nack_d     = 1'b0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                cyc_d = cyc_inc;
                if (tx_busy_i) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                cyc_d = cyc_inc;
                if ((cyc_q == ERR_S) && !io_sync_q) begin
                    nack_d = 1'b1;
                    if (nack_total_q != 16'hFFFF) begin
                        nack_total_d = nack_total_q + 16'd1;
                    end
                end
                if (!tx_busy_i && (cyc_q > ERR_S)) begin
                    etu_sub_d = 16'h0000;
                    etu_cnt_d = 10'h000;
                    state_d   = S_GUARD;
                end
            end
            S_GUARD: begin
                if (guard_done) begin
                    if (!nack_q) begin
                        byte_done_o = 1'b1;
                        state_d     = S_IDLE;
                    end else if (retry_q < MAX_R) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_LOAD;
                    end else begin
                        byte_fail_o = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else if (etu_sub_q == ETU_LAST) begin
                    etu_sub_d = 16'h0000;
                    etu_cnt_d = etu_cnt_q + 10'd1;
                end else begin
                    etu_sub_d = etu_sub_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (!tx_busy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats every other transition and suppresses any pulse of this cycle.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d     = S_DRAIN;
            retry_d     = retry_q;
            tx_start_o  = 1'b0;
            byte_done_o = 1'b0;
            byte_fail_o = 1'b0;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign retry_cnt_o  = retry_q;
    assign nack_total_o = nack_total_q;
    assign active_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_scard_tx_sequencer.sv
// Scoreboard bench for scard_tx_sequencer with a behavioural transmitter and card model.
module tb_scard_tx_sequencer;

    localparam int ETU      = 8;
    localparam int ERRS     = 92;
    localparam int GETU     = 2;
    localparam int MAXR     = 2;
    localparam int RW       = 3;
    localparam int BUSY_LEN = 104;
    localparam int NACK_ON  = 84;
    localparam int NACK_OFF = 100;

    typedef struct {
        int isFail;
        int retries;
        int nackTotal;
        int starts;
        int guardCycles;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic [7:0]    extra_guard = 8'h00;
    logic          abort = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic          io_in = 1'b1;
    logic          byte_done;
    logic          byte_fail;
    logic [RW-1:0] retry_cnt;
    logic [15:0]   nack_total;
    logic          active;

    int   compareCount = 0;
    int   failCount = 0;
    int   cycleNo = 0;
    int   fallCycle = 0;
    int   startCount = 0;
    int   pulseCount = 0;
    int   lastPulseCycle = -1;
    int   attempt = 0;
    logic [7:0] expData = 8'h00;
    logic [7:0] nackMask = 8'h00;
    exp_t expQ[$];

    scard_tx_sequencer #(
        .ETU_CLKS(ETU), .ERR_SAMPLE(ERRS), .GUARD_ETU(GETU), .MAX_RETRY(MAXR), .RETRY_W(RW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .extra_guard_i(extra_guard), .abort_i(abort),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy), .io_in_i(io_in),
        .byte_done_o(byte_done), .byte_fail_o(byte_fail), .retry_cnt_o(retry_cnt),
        .nack_total_o(nack_total), .active_o(active)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycleNo = cycleNo + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount = compareCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycleNo);
        end
    endtask

    // Transmitter stays busy BUSY_LEN cycles per frame; the card pulls io low around the sample point on NACK attempts.
    initial begin
        int busyCnt;
        bit nackThis;
        busyCnt  = -1;
        nackThis = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busyCnt = -1;
                tx_busy = 1'b0;
                io_in   = 1'b1;
            end else if (tx_start) begin
                busyCnt  = 0;
                tx_busy  = 1'b1;
                nackThis = (attempt < 8) ? nackMask[attempt] : 1'b0;
                attempt  = attempt + 1;
            end else if (busyCnt >= 0) begin
                busyCnt = busyCnt + 1;
                if (busyCnt == NACK_ON && nackThis) io_in = 1'b0;
                if (busyCnt == NACK_OFF) io_in = 1'b1;
                if (busyCnt == BUSY_LEN) begin
                    tx_busy   = 1'b0;
                    busyCnt   = -1;
                    fallCycle = cycleNo;
                end
            end
        end
    end

    // Monitor: checks every start pulse and pops one expectation per done/fail pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_start) begin
                    startCount = startCount + 1;
                    checkOutput("tx_data", int'(tx_data), int'(expData));
                end
                if (byte_done || byte_fail) begin
                    pulseCount     = pulseCount + 1;
                    lastPulseCycle = cycleNo;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_pulse", int'({byte_done, byte_fail}), 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("pulse_is_fail", int'(byte_fail), e.isFail);
                        checkOutput("pulse_is_done", int'(byte_done), 1 - e.isFail);
                        checkOutput("retry_cnt", int'(retry_cnt), e.retries);
                        checkOutput("nack_total", int'(nack_total), e.nackTotal);
                        checkOutput("start_count", startCount, e.starts);
                        checkOutput("guard_cycles", cycleNo - fallCycle, e.guardCycles);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input logic [7:0] eg, input logic [7:0] mask,
                                 input bit push, input exp_t e, input bit checkB2B);
        int n;
        in_valid    = 1'b1;
        in_data     = data;
        extra_guard = eg;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (checkB2B) checkOutput("b2b_ready_cycle", cycleNo, lastPulseCycle + 1);
        nackMask   = mask;
        attempt    = 0;
        startCount = 0;
        expData    = data;
        if (push) expQ.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("accept_latency", int'(tx_start), 1);
    endtask

    task automatic waitResponses(input int budget);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (expQ.size() > 0) begin
            checkOutput("response_timeout", expQ.size(), 0);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic waitBusy(input logic level, input int budget);
        int n;
        n = 0;
        while (tx_busy !== level && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (tx_busy !== level) checkOutput("tx_busy_timeout", int'(tx_busy), int'(level));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_tx_start"}, int'(tx_start), 0);
        checkOutput({tag, "_tx_data"}, int'(tx_data), 0);
        checkOutput({tag, "_byte_done"}, int'(byte_done), 0);
        checkOutput({tag, "_byte_fail"}, int'(byte_fail), 0);
        checkOutput({tag, "_retry_cnt"}, int'(retry_cnt), 0);
        checkOutput({tag, "_nack_total"}, int'(nack_total), 0);
        checkOutput({tag, "_active"}, int'(active), 0);
    endtask

    initial begin
        exp_t e;
        int p0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] clean byte 0xA5");
        e = '{0, 0, 0, 1, 16};
        applyStimulus(8'hA5, 8'd0, 8'b000, 1'b1, e, 1'b0);
        waitResponses(600);

        $display("[TB] byte 0x3C, NACK on first attempt");
        e = '{0, 1, 1, 2, 16};
        applyStimulus(8'h3C, 8'd0, 8'b001, 1'b1, e, 1'b0);
        waitResponses(800);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] byte 0xFF, NACK on every attempt");
        e = '{1, 2, 3, 3, 16};
        applyStimulus(8'hFF, 8'd0, 8'b111, 1'b1, e, 1'b0);
        waitResponses(1000);

        $display("[TB] extra guard 3 with back-to-back byte pending");
        e = '{0, 0, 3, 1, 40};
        applyStimulus(8'h5A, 8'd3, 8'b000, 1'b1, e, 1'b0);
        e = '{0, 0, 3, 1, 16};
        applyStimulus(8'h77, 8'd0, 8'b000, 1'b1, e, 1'b1);
        waitResponses(800);

        $display("[TB] abort during SEND");
        applyStimulus(8'h96, 8'd0, 8'b000, 1'b0, e, 1'b0);
        waitBusy(1'b1, 20);
        repeat (30) @(negedge clk);
        p0 = pulseCount;
        checkOutput("send_active", int'(active), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("drain_active", int'(active), 1);
        checkOutput("drain_in_ready", int'(in_ready), 0);
        waitBusy(1'b0, 300);
        @(negedge clk);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_idle", int'(active), 0);
        repeat (30) @(negedge clk);
        checkOutput("abort_starts", startCount, 1);
        checkOutput("abort_no_pulse", pulseCount, p0);

        $display("[TB] reset in GUARD");
        applyStimulus(8'hC3, 8'd2, 8'b000, 1'b0, e, 1'b0);
        waitBusy(1'b1, 20);
        waitBusy(1'b0, 300);
        repeat (5) @(negedge clk);
        checkOutput("guard_active", int'(active), 1);
        #2 rst = 1'b1;
        #1 checkResetValues("midguard");
        @(negedge clk);
        rst = 1'b0;
        p0 = pulseCount;
        repeat (80) @(negedge clk);
        checkOutput("reset_no_pulse", pulseCount, p0);
        checkOutput("reset_idle", int'(active), 0);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d comparisons made", compareCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
